ila_generator_mw: RTL and testbench

- Parametrised multi-octet successor of the single-octet ILA generator in the TX link layer.
- Emits a JESD204B initial lane alignment sequence of ILA_MF multiframes, OCTETS octets per character clock, aligned to the LMFC pulse.
- Outputs /K/ (K28.5) fill when idle.
- Sits between the CGS/sync FSM and the 8b/10b encoder of one lane.

---
 rtl/ila_generator_mw.sv | 194 +++++++++++++++++++
 tb/tb_ila_generator_mw.sv | 379 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ila_generator_mw.sv
// ila_generator_mw: JESD204B initial lane alignment generator, OCTETS octets
// per beat, ILA_MF multiframes per sequence, aligned to the LMFC pulse.
// Optional macro ILA_RAMP_EN: filler octets carry i[7:0] (a ramp restarting
// each multiframe) instead of 8'h00.
//
// state      | meaning
// IDLE       | /K/ fill, waiting for a rising edge of i_seq_start
// WAIT_LMFC  | config captured, /K/ fill until i_lmfc_pulse
// SEND       | ILA beats streaming, position kept by the internal count
`timescale 1ns/1ps
module ila_generator_mw #(
  parameter int OCTETS   = 4,
  parameter int ILA_MF   = 4,
  parameter int SUBCLASS = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                i_seq_start,
  input  logic                i_lmfc_pulse,
  input  logic [7:0]          i_DID,
  input  logic [3:0]          i_BID,
  input  logic [4:0]          i_LID,
  input  logic [4:0]          i_L,
  input  logic [7:0]          i_M,
  input  logic [4:0]          i_N,
  input  logic [1:0]          i_CS,
  input  logic [4:0]          i_N_ap,
  input  logic [7:0]          i_F,
  input  logic [4:0]          i_K,
  input  logic [4:0]          i_S,
  input  logic                i_HD,
  input  logic [4:0]          i_CF,
  input  logic                i_SCR,
  output logic [8*OCTETS-1:0] o_data,
  output logic [OCTETS-1:0]   o_k,
  output logic                o_vld,
  output logic                o_seq_end,
  output logic                o_cfg_err
);

  localparam logic [7:0]  K_CHAR     = 8'hBC;
  localparam logic [7:0]  R_CHAR     = 8'h1C;
  localparam logic [7:0]  A_CHAR     = 8'h7C;
  localparam logic [7:0]  Q_CHAR     = 8'h9C;
  localparam logic [13:0] OCT_STEP   = 14'(OCTETS);
  localparam logic [13:0] OCT_MASK   = 14'(OCTETS - 1);
  localparam logic [4:0]  LAST_MF    = 5'(ILA_MF - 1);
  localparam logic [2:0]  SUBCLASS_F = 3'(SUBCLASS);

  typedef enum logic [1:0] {IDLE, WAIT_LMFC, SEND} state_t;

  state_t           state;
  logic             seq_prev;
  logic [13:0]      oct_idx;
  logic [4:0]       mf_idx;
  logic [13:0]      fk_q;
  logic [13:0][7:0] cfg_q;

  logic [13:0]         fk_live;
  logic [13:0][7:0]    cfg_live;
  logic [7:0]          fchk_live;
  logic                cfg_ok;
  logic                seq_rise;
  logic                mf_wrap;
  logic                last_beat;
  logic [13:0]         oct_j;
  logic [3:0]          cfg_sel;
  logic [8*OCTETS-1:0] beat_data;
  logic [OCTETS-1:0]   beat_k;

  assign fk_live   = (14'(i_F) + 14'd1) * (14'(i_K) + 14'd1);
  assign cfg_ok    = (fk_live >= 14'd17) && ((fk_live & OCT_MASK) == 14'd0);
  assign seq_rise  = i_seq_start & ~seq_prev;
  assign mf_wrap   = (oct_idx + OCT_STEP) == fk_q;
  assign last_beat = mf_wrap && (mf_idx == LAST_MF);

  // Live link config octets; FCHK is summed here so it is registered at capture.
  always_comb begin
    cfg_live     = '0;
    cfg_live[0]  = i_DID;
    cfg_live[1]  = {4'h0, i_BID};
    cfg_live[2]  = {3'b000, i_LID};
    cfg_live[3]  = {i_SCR, 2'b00, i_L};
    cfg_live[4]  = i_F;
    cfg_live[5]  = {3'b000, i_K};
    cfg_live[6]  = i_M;
    cfg_live[7]  = {i_CS, 1'b0, i_N};
    cfg_live[8]  = {SUBCLASS_F, i_N_ap};
    cfg_live[9]  = {3'b001, i_S};
    cfg_live[10] = {i_HD, 2'b00, i_CF};
    fchk_live    = 8'h00;
    for (int c = 0; c < 13; c++) begin
      fchk_live = fchk_live + cfg_live[c];
    end
    cfg_live[13] = fchk_live;
  end

  // Octet content for the beat at (oct_idx, mf_idx); a beat never spans a
  // multiframe because FK is a multiple of OCTETS.
  always_comb begin
    beat_data = '0;
    beat_k    = '0;
    oct_j     = '0;
    cfg_sel   = '0;
    for (int j = 0; j < OCTETS; j++) begin
      oct_j   = oct_idx + 14'(j);
      cfg_sel = oct_j[3:0] - 4'd2;
      if (oct_j == 14'd0) begin
        beat_data[8*j +: 8] = R_CHAR;
        beat_k[j]           = 1'b1;
      end else if (oct_j == fk_q - 14'd1) begin
        beat_data[8*j +: 8] = A_CHAR;
        beat_k[j]           = 1'b1;
      end else if (mf_idx == 5'd1 && oct_j == 14'd1) begin
        beat_data[8*j +: 8] = Q_CHAR;
        beat_k[j]           = 1'b1;
      end else if (mf_idx == 5'd1 && oct_j <= 14'd15) begin
        beat_data[8*j +: 8] = cfg_q[cfg_sel];
      end else begin
`ifdef ILA_RAMP_EN
        beat_data[8*j +: 8] = oct_j[7:0];
`else
        beat_data[8*j +: 8] = 8'h00;
`endif
      end
    end
  end

  // Sequencing FSM with registered outputs; /K/ is the default every beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      seq_prev  <= 1'b0;
      oct_idx   <= '0;
      mf_idx    <= '0;
      fk_q      <= '0;
      cfg_q     <= '0;
      o_data    <= {OCTETS{K_CHAR}};
      o_k       <= '1;
      o_vld     <= 1'b0;
      o_seq_end <= 1'b0;
      o_cfg_err <= 1'b0;
    end else begin
      seq_prev  <= i_seq_start;
      o_data    <= {OCTETS{K_CHAR}};
      o_k       <= '1;
      o_vld     <= 1'b0;
      o_seq_end <= 1'b0;
      case (state)
        IDLE: begin
          oct_idx <= '0;
          mf_idx  <= '0;
          if (seq_rise) begin
            if (cfg_ok) begin
              o_cfg_err <= 1'b0;
              fk_q      <= fk_live;
              cfg_q     <= cfg_live;
              state     <= WAIT_LMFC;
            end else begin
              o_cfg_err <= 1'b1;
            end
          end
        end
        WAIT_LMFC, SEND: begin
          if (!i_seq_start) begin
            state   <= IDLE;
            oct_idx <= '0;
            mf_idx  <= '0;
          end else if (state == SEND || i_lmfc_pulse) begin
            o_data <= beat_data;
            o_k    <= beat_k;
            o_vld  <= 1'b1;
            if (last_beat) begin
              o_seq_end <= 1'b1;
              state     <= IDLE;
              oct_idx   <= '0;
              mf_idx    <= '0;
            end else begin
              state <= SEND;
              if (mf_wrap) begin
                oct_idx <= '0;
                mf_idx  <= mf_idx + 5'd1;
              end else begin
                oct_idx <= oct_idx + OCT_STEP;
              end
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ila_generator_mw.sv
// tb_ila_generator_mw: three generator instances (4, 1 and 2 octets per beat)
// share one stimulus; a stream-level reference predicts every output beat.
`timescale 1ns/1ps
module tb_ila_generator_mw;

  localparam int TB_SUBCLASS = 1;

  logic clk, rst_n, i_seq_start, i_lmfc_pulse;
  logic [7:0] i_DID, i_M, i_F;
  logic [3:0] i_BID;
  logic [4:0] i_LID, i_L, i_N, i_N_ap, i_K, i_S, i_CF;
  logic [1:0] i_CS;
  logic i_HD, i_SCR;

  logic [31:0] d4; logic [3:0] k4; logic v4, e4, c4;
  logic [7:0]  d1; logic [0:0] k1; logic v1, e1, c1;
  logic [15:0] d2; logic [1:0] k2; logic v2, e2, c2;

  int vectors, miscompares;

  ila_generator_mw #(.OCTETS(4), .ILA_MF(4), .SUBCLASS(TB_SUBCLASS)) dut4 (
    .clk(clk), .rst_n(rst_n), .i_seq_start(i_seq_start), .i_lmfc_pulse(i_lmfc_pulse),
    .i_DID(i_DID), .i_BID(i_BID), .i_LID(i_LID), .i_L(i_L), .i_M(i_M), .i_N(i_N),
    .i_CS(i_CS), .i_N_ap(i_N_ap), .i_F(i_F), .i_K(i_K), .i_S(i_S), .i_HD(i_HD),
    .i_CF(i_CF), .i_SCR(i_SCR),
    .o_data(d4), .o_k(k4), .o_vld(v4), .o_seq_end(e4), .o_cfg_err(c4));

  ila_generator_mw #(.OCTETS(1), .ILA_MF(4), .SUBCLASS(TB_SUBCLASS)) dut1 (
    .clk(clk), .rst_n(rst_n), .i_seq_start(i_seq_start), .i_lmfc_pulse(i_lmfc_pulse),
    .i_DID(i_DID), .i_BID(i_BID), .i_LID(i_LID), .i_L(i_L), .i_M(i_M), .i_N(i_N),
    .i_CS(i_CS), .i_N_ap(i_N_ap), .i_F(i_F), .i_K(i_K), .i_S(i_S), .i_HD(i_HD),
    .i_CF(i_CF), .i_SCR(i_SCR),
    .o_data(d1), .o_k(k1), .o_vld(v1), .o_seq_end(e1), .o_cfg_err(c1));

  ila_generator_mw #(.OCTETS(2), .ILA_MF(6), .SUBCLASS(TB_SUBCLASS)) dut2 (
    .clk(clk), .rst_n(rst_n), .i_seq_start(i_seq_start), .i_lmfc_pulse(i_lmfc_pulse),
    .i_DID(i_DID), .i_BID(i_BID), .i_LID(i_LID), .i_L(i_L), .i_M(i_M), .i_N(i_N),
    .i_CS(i_CS), .i_N_ap(i_N_ap), .i_F(i_F), .i_K(i_K), .i_S(i_S), .i_HD(i_HD),
    .i_CF(i_CF), .i_SCR(i_SCR),
    .o_data(d2), .o_k(k2), .o_vld(v2), .o_seq_end(e2), .o_cfg_err(c2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, want %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model (stream level) ----------------
  typedef struct packed {
    logic [31:0] data;
    logic [3:0]  k;
    logic        last;
  } beat_t;

  beat_t       mq [3][$];
  int          md [3];          // 0 idle, 1 armed, 2 streaming
  logic        m_err [3];
  logic [31:0] e_data [3];
  logic [3:0]  e_k [3];
  logic        e_vld [3];
  logic        e_end [3];
  logic        m_prev;

  function automatic int oct_of(input int p);
    return (p == 0) ? 4 : ((p == 1) ? 1 : 2);
  endfunction
  function automatic int mf_of(input int p);
    return (p == 2) ? 6 : 4;
  endfunction
  function automatic logic [31:0] dmask(input int p);
    return (p == 0) ? 32'hFFFF_FFFF : ((p == 1) ? 32'h0000_00FF : 32'h0000_FFFF);
  endfunction
  function automatic logic [3:0] kmask(input int p);
    return (p == 0) ? 4'hF : ((p == 1) ? 4'h1 : 4'h3);
  endfunction

  function automatic logic [7:0] cfg_octet(input int c);
    case (c)
      0:  return i_DID;
      1:  return {4'h0, i_BID};
      2:  return {3'b000, i_LID};
      3:  return {i_SCR, 2'b00, i_L};
      4:  return i_F;
      5:  return {3'b000, i_K};
      6:  return i_M;
      7:  return {i_CS, 1'b0, i_N};
      8:  return {3'(TB_SUBCLASS), i_N_ap};
      9:  return {3'b001, i_S};
      10: return {i_HD, 2'b00, i_CF};
      default: return 8'h00;
    endcase
  endfunction

  function automatic logic [7:0] fchk();
    int s;
    s = 0;
    for (int c = 0; c < 13; c++) s += int'(cfg_octet(c));
    return 8'(s % 256);
  endfunction

  function automatic logic [8:0] ila_octet(input int i, input int m, input int fk);
    if (i == 0)                       return {1'b1, 8'h1C};
    if (i == fk - 1)                  return {1'b1, 8'h7C};
    if (m == 1 && i == 1)             return {1'b1, 8'h9C};
    if (m == 1 && i >= 2 && i <= 15)  return {1'b0, (i == 15) ? fchk() : cfg_octet(i - 2)};
`ifdef ILA_RAMP_EN
    return {1'b0, 8'(i)};
`else
    return 9'h000;
`endif
  endfunction

  function automatic void build(input int p);
    int fk, oct, nb;
    beat_t bt;
    logic [8:0] o;
    fk  = (int'(i_F) + 1) * (int'(i_K) + 1);
    oct = oct_of(p);
    nb  = fk / oct;
    mq[p].delete();
    for (int m = 0; m < mf_of(p); m++) begin
      for (int b = 0; b < nb; b++) begin
        bt = '0;
        for (int j = 0; j < oct; j++) begin
          o = ila_octet(b * oct + j, m, fk);
          bt.data[8*j +: 8] = o[7:0];
          bt.k[j] = o[8];
        end
        bt.last = (m == mf_of(p) - 1) && (b == nb - 1);
        mq[p].push_back(bt);
      end
    end
  endfunction

  function automatic void model_reset();
    m_prev = 1'b0;
    for (int p = 0; p < 3; p++) begin
      md[p] = 0; m_err[p] = 1'b0; mq[p].delete();
      e_data[p] = 32'hBCBC_BCBC & dmask(p); e_k[p] = kmask(p);
      e_vld[p] = 1'b0; e_end[p] = 1'b0;
    end
  endfunction

  function automatic void model_step(input int p, input logic rise);
    int fk;
    beat_t bt;
    e_data[p] = 32'hBCBC_BCBC & dmask(p);
    e_k[p]    = kmask(p);
    e_vld[p]  = 1'b0;
    e_end[p]  = 1'b0;
    if (md[p] == 0) begin
      if (rise) begin
        fk = (int'(i_F) + 1) * (int'(i_K) + 1);
        if (fk < 17 || (fk % oct_of(p)) != 0) m_err[p] = 1'b1;
        else begin m_err[p] = 1'b0; build(p); md[p] = 1; end
      end
    end else if (!i_seq_start) begin
      md[p] = 0;
      mq[p].delete();
    end else if (md[p] == 2 || i_lmfc_pulse) begin
      if (mq[p].size() == 0) md[p] = 0;
      else begin
        bt = mq[p].pop_front();
        e_data[p] = bt.data; e_k[p] = bt.k; e_vld[p] = 1'b1; md[p] = 2;
        if (bt.last) begin e_end[p] = 1'b1; md[p] = 0; end
      end
    end
  endfunction

  initial begin
    logic rise;
    model_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) model_reset();
      else begin
        rise = i_seq_start && !m_prev;
        m_prev = i_seq_start;
        for (int p = 0; p < 3; p++) model_step(p, rise);
      end
    end
  end

  function automatic logic [31:0] act_data(input int p);
    return (p == 0) ? d4 : ((p == 1) ? {24'h0, d1} : {16'h0, d2});
  endfunction
  function automatic logic [3:0] act_k(input int p);
    return (p == 0) ? k4 : ((p == 1) ? {3'b0, k1} : {2'b0, k2});
  endfunction
  function automatic logic [2:0] act_flags(input int p);
    return (p == 0) ? {v4, e4, c4} : ((p == 1) ? {v1, e1, c1} : {v2, e2, c2});
  endfunction

  // Per-cycle comparison of every instance against the model.
  initial begin
    forever begin
      @(posedge clk); #2;
      for (int p = 0; p < 3; p++) begin
        check($sformatf("x%0d o_data", oct_of(p)), act_data(p), e_data[p]);
        check($sformatf("x%0d o_k", oct_of(p)), {28'h0, act_k(p)}, {28'h0, e_k[p]});
        check($sformatf("x%0d vld/end/err", oct_of(p)), {29'h0, act_flags(p)},
              {29'h0, e_vld[p], e_end[p], m_err[p]});
      end
    end
  end

  // ---------------- stimulus ----------------
  typedef struct {
    logic [7:0] f;
    logic [4:0] k;
    logic       err4;
    logic       err1;
    logic       err2;
  } cfg_vec_t;

  cfg_vec_t tbl [8];

`ifdef ILA_RAMP_EN
  localparam logic [31:0] BEAT0_X4 = 32'h0302_011C;
  localparam logic [15:0] BEAT1_X2 = 16'h0302;
`else
  localparam logic [31:0] BEAT0_X4 = 32'h0000_001C;
  localparam logic [15:0] BEAT1_X2 = 16'h0000;
`endif

  task automatic tick();
    @(posedge clk); #3;
  endtask

  task automatic set_cfg(input logic [7:0] f, input logic [4:0] k, input logic [7:0] did);
    i_F = f; i_K = k; i_DID = did;
    i_BID = '0; i_LID = '0; i_L = '0; i_M = '0; i_N = '0; i_CS = '0;
    i_N_ap = '0; i_S = '0; i_HD = 1'b0; i_CF = '0; i_SCR = 1'b0;
  endtask

  task automatic arm_and_pulse();
    i_seq_start = 1'b1; tick();
    i_lmfc_pulse = 1'b1; tick();
    i_lmfc_pulse = 1'b0;
  endtask

  initial begin
    int n4, n1, ends4, ends1, end4, extra, ends_ab, len;
    vectors = 0; miscompares = 0;
    rst_n = 1'b0; i_seq_start = 1'b0; i_lmfc_pulse = 1'b0;
    set_cfg(8'd1, 5'd15, 8'h01);

    tbl[0] = '{8'd0, 5'd7,  1'b1, 1'b1, 1'b1};   // FK 8
    tbl[1] = '{8'd1, 5'd15, 1'b0, 1'b0, 1'b0};   // FK 32
    tbl[2] = '{8'd0, 5'd16, 1'b1, 1'b0, 1'b1};   // FK 17
    tbl[3] = '{8'd1, 5'd8,  1'b1, 1'b0, 1'b0};   // FK 18
    tbl[4] = '{8'd3, 5'd3,  1'b1, 1'b1, 1'b1};   // FK 16
    tbl[5] = '{8'd0, 5'd19, 1'b0, 1'b0, 1'b0};   // FK 20
    tbl[6] = '{8'd4, 5'd4,  1'b1, 1'b0, 1'b1};   // FK 25
    tbl[7] = '{8'd2, 5'd5,  1'b1, 1'b0, 1'b0};   // FK 18

    repeat (3) tick();
    rst_n = 1'b1;
    repeat (2) tick();
    check("reset o_data", d4, 32'hBCBC_BCBC);
    check("reset o_k", {28'h0, k4}, 32'hF);
    check("reset vld/end/err", {29'h0, v4, e4, c4}, 32'h0);

    // Config legality table
    foreach (tbl[t]) begin
      set_cfg(tbl[t].f, tbl[t].k, 8'h5A);
      i_seq_start = 1'b1; tick();
      check($sformatf("tbl%0d cfg_err x4", t), {31'h0, c4}, {31'h0, tbl[t].err4});
      check($sformatf("tbl%0d cfg_err x1", t), {31'h0, c1}, {31'h0, tbl[t].err1});
      check($sformatf("tbl%0d cfg_err x2", t), {31'h0, c2}, {31'h0, tbl[t].err2});
      i_seq_start = 1'b0; repeat (2) tick();
    end

    // Full sequence, FK = 32
    set_cfg(8'd1, 5'd15, 8'h01);
    arm_and_pulse();
    n4 = 0; n1 = 0; ends4 = 0; ends1 = 0; end4 = -1;
    for (int c = 0; c < 140; c++) begin
      if (v4) n4++;
      if (e4) begin ends4++; end4 = c; end
      if (v1) n1++;
      if (e1) ends1++;
      if (c == 0) begin
        check("x4 beat0 data", d4, BEAT0_X4);
        check("x4 beat0 k", {28'h0, k4}, 32'h1);
        check("x1 beat0 data", {24'h0, d1}, 32'h1C);
      end
      if (c == 1) begin
        check("x2 beat1 data", {16'h0, d2}, {16'h0, BEAT1_X2});
        check("x2 beat1 k", {30'h0, k2}, 32'h0);
      end
      if (c == 8) begin
        check("x4 beat8 data", d4, 32'h0001_9C1C);
        check("x4 beat8 k", {28'h0, k4}, 32'h3);
      end
      if (c == 11) check("x4 fchk octet", {24'h0, d4[31:24]}, 32'h51);
      if (c == 31) check("x4 beat31 /A/", {23'h0, k4[3], d4[31:24]}, 32'h17C);
      if (c == 32) check("x4 post-seq /K/", d4, 32'hBCBC_BCBC);
      tick();
    end
    check("x4 vld beats", n4, 32);
    check("x4 seq_end count", ends4, 1);
    check("x4 seq_end beat", end4, 31);
    check("x1 vld beats", n1, 128);
    check("x1 seq_end count", ends1, 1);
    extra = 0;
    for (int c = 0; c < 20; c++) begin
      if (v4 || v1 || v2) extra++;
      tick();
    end
    check("no restart while held", extra, 0);
    i_seq_start = 1'b0; repeat (2) tick();

    // Abort on beat 5
    set_cfg(8'd1, 5'd15, 8'h07);
    arm_and_pulse();
    repeat (5) tick();
    check("abort beat5 vld", {31'h0, v4}, 32'h1);
    i_seq_start = 1'b0; tick();
    check("abort beat6 data", d4, 32'hBCBC_BCBC);
    check("abort beat6 k/vld", {27'h0, k4, v4}, {27'h0, 4'hF, 1'b0});
    ends_ab = 0;
    for (int c = 0; c < 10; c++) begin
      if (e4 || e1 || e2) ends_ab++;
      tick();
    end
    check("abort no seq_end", ends_ab, 0);

    // Asynchronous reset mid-sequence
    set_cfg(8'd0, 5'd31, 8'h03);
    arm_and_pulse();
    repeat (10) tick();
    check("pre-reset vld", {31'h0, v4}, 32'h1);
    rst_n = 1'b0; i_seq_start = 1'b0;
    #1;
    check("async rst data", d4, 32'hBCBC_BCBC);
    check("async rst k/vld", {27'h0, k4, v4}, {27'h0, 4'hF, 1'b0});
    check("async rst x1 vld", {31'h0, v1}, 32'h0);
    repeat (2) tick();
    rst_n = 1'b1;
    for (int c = 0; c < 5; c++) begin
      tick();
      check("post-reset idle", {31'h0, v4}, 32'h0);
    end

    // Randomized traffic, checked cycle by cycle against the model
    for (int t = 0; t < 30; t++) begin
      set_cfg(8'($urandom_range(0, 3)), 5'($urandom_range(0, 31)), 8'($urandom));
      i_BID = 4'($urandom); i_LID = 5'($urandom); i_L = 5'($urandom);
      i_M = 8'($urandom); i_N = 5'($urandom); i_CS = 2'($urandom);
      i_N_ap = 5'($urandom); i_S = 5'($urandom); i_HD = 1'($urandom);
      i_CF = 5'($urandom); i_SCR = 1'($urandom);
      len = $urandom_range(20, 700);
      for (int c = 0; c < len; c++) begin
        i_lmfc_pulse = ($urandom_range(0, 5) == 0);
        if ($urandom_range(0, 49) == 0) i_DID = 8'($urandom);
        i_seq_start = ($urandom_range(0, 199) != 0);
        tick();
      end
      i_lmfc_pulse = 1'b0; i_seq_start = 1'b0;
      repeat (3) tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not complete, got timeout, want finish");
    $fatal(1);
  end

endmodule
